tt_um_uart_tx: RTL and testbench



---
 rtl/tt_um_uart_tx.sv | 151 +++++++++++++++
 tb/tb_tt_um_uart_tx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_uart_tx.sv
// -----------------------------------------------------------------------------
// tt_um_uart_tx
//
// Tiny Tapeout user module: transmits one byte taken from ui_in as an 8N1 UART
// frame (start bit, 8 data bits LSB first, stop bit) on uo_out[0].
//
// A frame is requested by a rising edge on uio_in[0]. That pin is treated as
// an asynchronous level, so it goes through a two-flop synchroniser and an
// edge detector first. The byte on ui_in is captured on the clock edge at
// which the frame starts. Any later change on ui_in is ignored until the
// next frame.
//
// Ports (standard tt_um pin set):
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   ena      in   design selected; while low no new frame may start
//   ui_in    in   [7:0] byte to transmit
//   uio_in   in   [0] send request (async level), [7:1] unused
//   uo_out   out  [0] tx line, [1] busy, [2] done pulse, [7:3] zero
//   uio_out  out  constant 0
//   uio_oe   out  constant 0 (all uio pins are inputs)
//
// Every bit of uo_out comes straight from a flop. No combinational path
// runs from any input to the pins.
// -----------------------------------------------------------------------------
module tt_um_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16  // legal range 2..65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e        state_q;
  logic          s1_q, s2_q, p_q;     // synchroniser stages and previous value
  logic [7:0]    shift_q;             // byte being shifted out, LSB first
  logic [CW-1:0] cnt_q;               // clock cycles spent in the current bit
  logic [2:0]    idx_q;               // index of the data bit on the line
  logic          tx_q, busy_q, done_q;
  logic          start;

  // A request counts only on a fresh synchronised 0->1 while idle and selected.
  // Edges seen during a frame, or while ena is low, are lost and not queued.
  // p_q keeps following s2_q in every state. A level held high therefore
  // never looks like a new edge once the frame has finished.
  assign start = s2_q & ~p_q & ena & (state_q == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here is written with <= so that all flops sample
    // their inputs from before the edge. With blocking '=', s2_q would see the
    // s1_q value from the same edge and the synchroniser would collapse.
    if (!rst_n) begin
      state_q <= IDLE;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      p_q     <= 1'b0;
      shift_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;    // line idles high, even while held in reset
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      s1_q   <= uio_in[0];
      s2_q   <= s1_q;
      p_q    <= s2_q;
      done_q <= 1'b0;     // single-cycle pulse, set only on leaving STOP

      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          cnt_q  <= '0;
          if (start) begin
            shift_q <= ui_in;
            state_q <= START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end

        START: begin
          if (cnt_q == CNT_MAX) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        DATA: begin
          if (cnt_q == CNT_MAX) begin
            cnt_q   <= '0;
            shift_q <= shift_q >> 1;
            if (idx_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              idx_q <= idx_q + 3'd1;
              // tx is registered, so load the bit that the shift brings
              // into position 0 now. That keeps the line in step with
              // shift_q.
              tx_q  <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        STOP: begin
          if (cnt_q == CNT_MAX) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign uo_out  = {5'b0, done_q, busy_q, tx_q};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  // uio_in[7:1] are part of the fixed pin set but carry nothing.
  logic unused_ok;
  assign unused_ok = &{1'b0, uio_in[7:1]};

endmodule

// File: tb/tb_tt_um_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_tt_um_uart_tx
//
// Self-checking bench for tt_um_uart_tx with CLKS_PER_BIT = 16.
// Directed scenarios run from one initial block. Outputs are sampled 1 ns
// after the rising edge. Inputs are driven off the edge with blocking
// assignments.
// -----------------------------------------------------------------------------
module tb_tt_um_uart_tx;

  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_cmp = 0;
  int n_bad = 0;

  tt_um_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  // Set the byte and raise send between edges. The next rising edge is the
  // capture edge k.
  task automatic start_send(input logic [7:0] data);
    @(negedge clk);
    ui_in     = data;
    uio_in[0] = 1'b1;
  endtask

  // Follows one frame from the capture edge k, which is the next rising edge,
  // through the cycle after done. j counts edges from k+2, where the start bit
  // should appear. poke_at < 0 and ena_drop_at < 0 turn those disturbances off.
  task automatic run_frame(input logic [7:0] data, input string name,
                           input int poke_at, input int ena_drop_at,
                           input bit hold_send);
    logic [9:0] bits;
    int         busy_cycles;
    bits        = {1'b1, data, 1'b0};
    busy_cycles = 0;

    @(posedge clk); #1;                       // edge k
    if (!hold_send) uio_in[0] = 1'b0;
    @(posedge clk); #1;                       // edge k+1: not started yet
    n_cmp++;
    if (uo_out[1:0] !== 2'b01) begin
      n_bad++;
      $display("FAIL %s pre_start: tx/busy=%b expected 01", name, uo_out[1:0]);
    end

    for (int j = 0; j <= FRAME; j++) begin
      @(posedge clk); #1;
      if (j == 0) begin
        n_cmp++;
        if (uo_out[1:0] !== 2'b10) begin
          n_bad++;
          $display("FAIL %s start_edge: tx/busy=%b expected 10", name, uo_out[1:0]);
        end
        ui_in = ~data;                        // must not affect the frame
      end
      if (j < FRAME && uo_out[1] === 1'b1) busy_cycles++;
      if (j < FRAME && (j % CPB) == CPB / 2) begin
        n_cmp++;
        if (uo_out[0] !== bits[j / CPB]) begin
          n_bad++;
          $display("FAIL %s bit%0d: tx=%b expected %b", name, j / CPB,
                   uo_out[0], bits[j / CPB]);
        end
      end
      if (j == poke_at) begin
        ui_in     = 8'h3C;
        uio_in[0] = 1'b1;
      end
      if (j == poke_at + 3 && !hold_send) uio_in[0] = 1'b0;
      if (j == ena_drop_at) ena = 1'b0;
    end

    // j == FRAME: busy has fallen, done is high, and the line is idle.
    n_cmp++;
    if (busy_cycles != FRAME) begin
      n_bad++;
      $display("FAIL %s busy_len: %0d cycles expected %0d", name, busy_cycles, FRAME);
    end
    n_cmp++;
    if (uo_out !== 8'h05) begin
      n_bad++;
      $display("FAIL %s done_set: uo_out=%h expected 05", name, uo_out);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (uo_out !== 8'h01) begin
      n_bad++;
      $display("FAIL %s done_clear: uo_out=%h expected 01", name, uo_out);
    end
    ena = 1'b1;
  endtask

  // Checks that busy stays low and tx stays high for n cycles.
  task automatic expect_idle(input string name, input int n);
    int bad_cycles;
    bad_cycles = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (uo_out !== 8'h01) bad_cycles++;
    end
    n_cmp++;
    if (bad_cycles != 0) begin
      n_bad++;
      $display("FAIL %s idle: %0d non-idle cycles expected 0", name, bad_cycles);
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'hC3;
    uio_in = 8'hFF;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (uo_out !== 8'h01) begin
      n_bad++;
      $display("FAIL reset_uo_out: got %h expected 01", uo_out);
    end
    n_cmp++;
    if (uio_out !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_uio_out: got %h expected 00", uio_out);
    end
    n_cmp++;
    if (uio_oe !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_uio_oe: got %h expected 00", uio_oe);
    end
    uio_in = 8'h00;
    ui_in  = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    expect_idle("after_reset", 5);
  endtask

  task automatic test_basic_bytes();
    start_send(8'hA5); run_frame(8'hA5, "byte_a5", -1, -1, 1'b0);
    start_send(8'h00); run_frame(8'h00, "byte_00", -1, -1, 1'b0);
    start_send(8'hFF); run_frame(8'hFF, "byte_ff", -1, -1, 1'b0);
  endtask

  task automatic test_ignore_busy_edge();
    start_send(8'hA5);
    run_frame(8'hA5, "busy_edge", 60, -1, 1'b0);
    expect_idle("busy_edge_dropped", 30);
  endtask

  task automatic test_held_send();
    start_send(8'h5A);
    run_frame(8'h5A, "held", -1, -1, 1'b1);
    expect_idle("held_no_retrigger", 240);  // about 400 cycles high in total
    @(negedge clk);
    uio_in[0] = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_ena();
    @(negedge clk);
    ena = 1'b0;
    start_send(8'h77);
    @(posedge clk); #1;
    uio_in[0] = 1'b0;
    expect_idle("ena_low_no_frame", 40);
    @(negedge clk);
    ena = 1'b1;
    start_send(8'h96);
    run_frame(8'h96, "ena_drop_mid", 50, 50, 1'b0);
    expect_idle("ena_drop_after", 10);
  endtask

  task automatic test_back_to_back();
    start_send(8'h12); run_frame(8'h12, "b2b_first", -1, -1, 1'b0);
    start_send(8'h34); run_frame(8'h34, "b2b_second", -1, -1, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    start_send(8'h00);
    @(posedge clk); #1;
    uio_in[0] = 1'b0;
    repeat (2 + 40) @(posedge clk);  // into data bit 1, which sends a 0
    #1;
    n_cmp++;
    if (uo_out[1:0] !== 2'b10) begin
      n_bad++;
      $display("FAIL midreset_pre: tx/busy=%b expected 10", uo_out[1:0]);
    end
    rst_n = 1'b0;
    #1;                               // no clock edge in between
    n_cmp++;
    if (uo_out !== 8'h01) begin
      n_bad++;
      $display("FAIL midreset_abort: uo_out=%h expected 01", uo_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    expect_idle("midreset_after", 20);
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    test_reset();
    test_basic_bytes();
    test_ignore_busy_edge();
    test_held_send();
    test_ena();
    test_back_to_back();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
